im_loader: RTL

Boot-time instruction memory loader: receives a framed byte stream from a host link (UART receiver or debug bridge), assembles big-endian 32-bit instruction words, and writes them into the instruction memory through its write port (`imaddr`/`imwe`/`imdin`/`imce`). It is the writer end of the IM interface whose read end is the fetch stage. It holds the CPU in reset until a load completes with a valid checksum.

---
 rtl/im_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// Boot-time instruction memory loader: parses a length/payload/checksum byte
// frame, writes big-endian words into IM and keeps the CPU in reset until a good load.
module im_loader #(
    parameter int ADDR_W      = 13,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] imaddr,
    output logic              imwe,
    output logic [31:0]       imdin,
    output logic              imce,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              hold_cpu,
    output logic [15:0]       words_loaded,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on any rising edge where rx_valid && rx_ready;
    // rx_ready is registered and never depends on rx_valid.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam int          CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t           state, next_state;
    logic             armed;
    logic [7:0]       len_hi_q;
    logic [15:0]      n_words;
    logic [1:0]       byte_idx;
    logic [23:0]      word_sr;
    logic [7:0]       csum;
    logic [CNT_W-1:0] to_cnt;

    logic        xfer, start_ok, timed_out, waiting;
    logic [15:0] len_n, wl_next;

    assign xfer      = rx_valid && rx_ready;
    assign start_ok  = start && armed;
    assign len_n     = {len_hi_q, rx_data};
    assign wl_next   = words_loaded + 16'd1;
    assign waiting   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign timed_out = waiting && !xfer && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign dbg_state = state;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) state <= S_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start_ok) next_state = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer)           next_state = S_LEN_LO;
                else if (timed_out) next_state = S_ERR;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_n == 16'd0)                 next_state = S_CSUM;
                    else if ({1'b0, len_n} > MAX_WORDS) next_state = S_ERR;
                    else                                next_state = S_DATA;
                end else if (timed_out) begin
                    next_state = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer && byte_idx == 2'd3) next_state = S_WRITE;
                else if (timed_out)           next_state = S_ERR;
            end
            S_WRITE: next_state = (wl_next < n_words) ? S_DATA : S_CSUM;
            S_CSUM: begin
                if (xfer)           next_state = (rx_data == csum) ? S_DONE : S_ERR;
                else if (timed_out) next_state = S_ERR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Idle-gap counter restarts on every accepted byte and every state change.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n)                        to_cnt <= '0;
        else if (xfer || next_state != state) to_cnt <= '0;
        else if (waiting)                      to_cnt <= to_cnt + 1'b1;
        else                                   to_cnt <= '0;
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            armed        <= 1'b0;
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            imwe         <= 1'b0;
            imce         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            hold_cpu     <= 1'b1;
            imaddr       <= '0;
            imdin        <= '0;
            words_loaded <= '0;
            len_hi_q     <= '0;
            n_words      <= '0;
            byte_idx     <= '0;
            word_sr      <= '0;
            csum         <= '0;
        end else begin
            armed    <= 1'b1;
            rx_ready <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                        (next_state == S_DATA)   || (next_state == S_CSUM);
            busy     <= (next_state != S_IDLE) && (next_state != S_DONE) &&
                        (next_state != S_ERR);
            imwe     <= (next_state == S_WRITE);
            imce     <= (next_state == S_WRITE);
            done     <= (next_state == S_DONE);
            err      <= (next_state == S_ERR);
            hold_cpu <= (next_state != S_DONE);
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ok) begin
                        words_loaded <= '0;
                        csum         <= '0;
                        byte_idx     <= '0;
                    end
                end
                S_LEN_HI: if (xfer) len_hi_q <= rx_data;
                S_LEN_LO: if (xfer) n_words <= len_n;
                S_DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ rx_data;
                        word_sr  <= {word_sr[15:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imaddr <= words_loaded[ADDR_W-1:0];
                            imdin  <= {word_sr, rx_data};
                        end
                    end
                end
                S_WRITE: words_loaded <= wl_next;
                default: ;
            endcase
        end
    end

endmodule
